// File: rtl/bg_fetch_pipe.sv
// Background tile fetch pipeline. Walks the 8-dot nametable / attribute /
// pattern-lo / pattern-hi fetch sequence and feeds 16-bit pattern and
// attribute shifters. Emits one 4-bit background palette index per visible dot.
module bg_fetch_pipe #(
   parameter int unsigned MIRROR_MODE    = 1,
   parameter int unsigned VIS_ROWS       = 240,
   parameter int unsigned PREFETCH_START = 321
) (
   input  logic        clk,
   input  logic        clk_en,
   input  logic        rst_n,
   input  logic [8:0]  row,
   input  logic [8:0]  col,
   input  logic        bg_enable,
   input  logic        show_left8,
   input  logic [1:0]  name_tbl,
   input  logic        patt_tbl,
   input  logic [7:0]  scroll_x,
   input  logic [7:0]  scroll_y,
   output logic [10:0] vram_addr,
   input  logic [7:0]  vram_data,
   output logic [12:0] chr_addr,
   input  logic [7:0]  chr_data,
   output logic [3:0]  bg_pix,
   output logic        bg_valid
);

   localparam logic [8:0] VIS_ROWS_W = 9'(VIS_ROWS);
   localparam logic [8:0] PRE_ROW    = 9'd261;
   localparam logic [8:0] SAMPLE_COL = 9'(PREFETCH_START - 1);
   localparam logic [8:0] PF_FIRST   = 9'(PREFETCH_START);
   localparam logic [8:0] PF_MID     = 9'(PREFETCH_START + 8);
   localparam logic [8:0] PF_LAST   = 9'(PREFETCH_START + 15);
   localparam logic [8:0] PF_END     = 9'(PREFETCH_START + 16);

   // Shadow copies of the scroll/table registers, frozen for a whole row.
   logic [7:0]  sh_sx;
   logic [7:0]  sh_sy;
   logic [1:0]  sh_nt;
   logic        sh_patt;

   // Fetch latches.
   logic [7:0]  nt_lat;
   logic [1:0]  at_lat;
   logic [7:0]  lo_lat;
   logic [7:0]  hi_lat;

   // Pixel shifters and their next values.
   logic [15:0] pt_lo, pt_hi, at_lo, at_hi;
   logic [15:0] pt_lo_nxt, pt_hi_nxt, at_lo_nxt, at_hi_nxt;

   // Set once a full prefetch has landed in the shifters since reset.
   logic        primed;

   // Dot/window decode.
   logic [7:0]  dot_m1;
   logic [2:0]  phase;
   logic        render_row, vis_row, in_vis_win, in_pf_win;
   logic        fetch_en, shift_en, reload_en, vis_dot;

   // Tile coordinates and derived addresses.
   logic [5:0]  tile_n;
   logic [5:0]  px_t;        // px[8:3]
   logic [8:0]  tgt_row;
   logic [9:0]  py_raw;
   logic        py_wrap;
   logic [7:0]  py;
   logic [1:0]  lnt;
   logic        a10;
   logic [10:0] nt_addr, at_addr;
   logic [12:0] chr_lo_addr, chr_hi_addr;
   logic [1:0]  quad;

   // Pixel selection.
   logic [3:0]  sel;
   logic [1:0]  color, pal;
   logic        pix_on;

   // Decode the current dot into fetch/shift windows and tile coordinates.
   // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
   always_comb begin
      dot_m1     = 8'(col - 9'd1);
      phase      = dot_m1[2:0];
      vis_row    = (row < VIS_ROWS_W);
      render_row = vis_row || (row == PRE_ROW);
      in_vis_win = (col >= 9'd1) && (col <= 9'd256);
      in_pf_win  = (col >= PF_FIRST) && (col <= PF_LAST);
      fetch_en   = bg_enable && render_row && (in_vis_win || in_pf_win);
      shift_en   = bg_enable && render_row &&
                   (((col >= 9'd2) && (col <= 9'd257)) ||
                    ((col >= PF_FIRST + 9'd1) && (col <= PF_END)));
      reload_en  = shift_en && (phase == 3'd0);
      vis_dot    = vis_row && in_vis_win;

      tile_n = 6'd0;
      if (in_vis_win)
         tile_n = {1'b0, dot_m1[7:3]} + 6'd2;
      else if (col >= PF_MID)
         tile_n = 6'd1;
      px_t = {1'b0, sh_sx[7:3]} + tile_n;

      tgt_row = row;
      if (row == PRE_ROW)
         tgt_row = 9'd0;
      else if (in_pf_win)
         tgt_row = row + 9'd1;
      py_raw  = {2'b00, sh_sy} + {1'b0, tgt_row};
      py_wrap = (py_raw >= 10'd240);
      py      = py_wrap ? 8'(py_raw - 10'd240) : py_raw[7:0];

      lnt = sh_nt ^ {py_wrap, px_t[5]};
      a10 = (MIRROR_MODE != 0) ? lnt[0] : lnt[1];

      nt_addr     = {a10, py[7:3], px_t[4:0]};
      at_addr     = {a10, 4'hF, py[7:5], px_t[4:2]};
      chr_lo_addr = {sh_patt, nt_lat, 1'b0, py[2:0]};
      chr_hi_addr = {sh_patt, nt_lat, 1'b1, py[2:0]};

      case ({py[4], px_t[1]})
         2'b00:   quad = vram_data[1:0];
         2'b01:   quad = vram_data[3:2];
         2'b10:   quad = vram_data[5:4];
         default: quad = vram_data[7:6];
      endcase
   end

   // Capture scroll and table selection once per row, just before the prefetch.
   // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_sx   <= 8'd0;
         sh_sy   <= 8'd0;
         sh_nt   <= 2'd0;
         sh_patt <= 1'b0;
      end else if (clk_en && (col == SAMPLE_COL)) begin
         sh_sx   <= scroll_x;
         sh_sy   <= scroll_y;
         sh_nt   <= name_tbl;
         sh_patt <= patt_tbl;
      end
   end

   // Eight-phase fetch sequencer: drive an address, then latch its data a tick later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vram_addr <= 11'd0;
         chr_addr  <= 13'd0;
         nt_lat    <= 8'd0;
         at_lat    <= 2'd0;
         lo_lat    <= 8'd0;
         hi_lat    <= 8'd0;
      end else if (clk_en && fetch_en) begin
         case (phase)
            3'd0: vram_addr <= nt_addr;
            3'd1: nt_lat    <= vram_data;
            3'd2: vram_addr <= at_addr;
            3'd3: at_lat    <= quad;
            3'd4: chr_addr  <= chr_lo_addr;
            3'd5: lo_lat    <= chr_data;
            3'd6: chr_addr  <= chr_hi_addr;
            3'd7: hi_lat    <= chr_data;
         endcase
      end
   end

   // Next shifter contents: shift left, then refill the low byte on tile boundaries.
   always_comb begin
      pt_lo_nxt = pt_lo;
      pt_hi_nxt = pt_hi;
      at_lo_nxt = at_lo;
      at_hi_nxt = at_hi;
      if (shift_en) begin
         pt_lo_nxt = {pt_lo[14:0], 1'b0};
         pt_hi_nxt = {pt_hi[14:0], 1'b0};
         at_lo_nxt = {at_lo[14:0], 1'b0};
         at_hi_nxt = {at_hi[14:0], 1'b0};
         if (reload_en) begin
            pt_lo_nxt[7:0] = lo_lat;
            pt_hi_nxt[7:0] = hi_lat;
            at_lo_nxt[7:0] = {8{at_lat[0]}};
            at_hi_nxt[7:0] = {8{at_lat[1]}};
         end
      end
   end

   // Shifter registers advance only on dot-enable ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pt_lo <= 16'd0;
         pt_hi <= 16'd0;
         at_lo <= 16'd0;
         at_hi <= 16'd0;
      end else if (clk_en) begin
         pt_lo <= pt_lo_nxt;
         pt_hi <= pt_hi_nxt;
         at_lo <= at_lo_nxt;
         at_hi <= at_hi_nxt;
      end
   end

   // Pick the fine-X bit from the shifter view that belongs to this dot.
   always_comb begin
      sel    = 4'd15 - {1'b0, sh_sx[2:0]};
      color  = {pt_hi_nxt[sel], pt_lo_nxt[sel]};
      pal    = {at_hi_nxt[sel], at_lo_nxt[sel]};
      pix_on = bg_enable && !((col <= 9'd8) && !show_left8) && (color != 2'b00);
   end

   // Register the pixel output; suppress everything until a prefetch has completed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bg_pix   <= 4'h0;
         bg_valid <= 1'b0;
         primed   <= 1'b0;
      end else if (clk_en) begin
         if (render_row && (col == PF_END))
            primed <= 1'b1;
         bg_valid <= vis_dot && primed;
         bg_pix   <= (vis_dot && primed && pix_on) ? {pal, color} : 4'h0;
      end
   end

endmodule

// File: tb/tb_bg_fetch_pipe.sv
// Bench for bg_fetch_pipe: drives row/col directly, models VRAM/CHR as
// synchronous-read arrays and scoreboards pixel outputs against
// hand-computed per-tile patterns.
module tb_bg_fetch_pipe;

   logic        clk;
   logic        clk_en;
   logic        rst_n;
   logic [8:0]  row;
   logic [8:0]  col;
   logic        bg_enable;
   logic        show_left8;
   logic [1:0]  name_tbl;
   logic        patt_tbl;
   logic [7:0]  scroll_x;
   logic [7:0]  scroll_y;
   logic [10:0] vram_addr, vram_addr_h;
   logic [7:0]  vram_data, vram_data_h;
   logic [12:0] chr_addr, chr_addr_h;
   logic [7:0]  chr_data, chr_data_h;
   logic [3:0]  bg_pix, bg_pix_h;
   logic        bg_valid, bg_valid_h;

   // Vertical-mirroring instance (scoreboarded) and horizontal one (address checks).
   bg_fetch_pipe #(.MIRROR_MODE(1)) dut (
      .clk(clk), .clk_en(clk_en), .rst_n(rst_n), .row(row), .col(col),
      .bg_enable(bg_enable), .show_left8(show_left8), .name_tbl(name_tbl),
      .patt_tbl(patt_tbl), .scroll_x(scroll_x), .scroll_y(scroll_y),
      .vram_addr(vram_addr), .vram_data(vram_data), .chr_addr(chr_addr),
      .chr_data(chr_data), .bg_pix(bg_pix), .bg_valid(bg_valid)
   );

   bg_fetch_pipe #(.MIRROR_MODE(0)) dut_h (
      .clk(clk), .clk_en(clk_en), .rst_n(rst_n), .row(row), .col(col),
      .bg_enable(bg_enable), .show_left8(show_left8), .name_tbl(name_tbl),
      .patt_tbl(patt_tbl), .scroll_x(scroll_x), .scroll_y(scroll_y),
      .vram_addr(vram_addr_h), .vram_data(vram_data_h), .chr_addr(chr_addr_h),
      .chr_data(chr_data_h), .bg_pix(bg_pix_h), .bg_valid(bg_valid_h)
   );

   logic [7:0] vram_mem [0:2047];
   logic [7:0] chr_mem  [0:8191];

   always @(posedge clk) begin
      vram_data   <= vram_mem[vram_addr];
      chr_data    <= chr_mem[chr_addr];
      vram_data_h <= vram_mem[vram_addr_h];
      chr_data_h  <= chr_mem[chr_addr_h];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         r;
      int         c;
      logic [3:0] pix;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [3:0] exp_tile [0:7];
   logic       tb_primed;
   logic       en_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: one sample per dot tick, pops the scoreboard whenever bg_valid is high.
   always @(posedge clk) en_q <= clk_en;

   always @(negedge clk) begin
      if (en_q && bg_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got pix 0x%0h at r%0d c%0d, expected no output",
                     bg_pix, row, col);
         end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("pix r%0d c%0d", mon_e.r, mon_e.c), 32'(bg_pix), 32'(mon_e.pix));
         end
      end
   end

   task automatic set_first(input logic [3:0] p);
      for (int i = 0; i < 8; i++) exp_tile[i] = 4'h0;
      exp_tile[0] = p;
   endtask

   // Every nametable byte = tile 1; every attribute byte = attr; tile 1 rows = lo/hi.
   task automatic load_mem(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] attr);
      for (int i = 0; i < 2048; i++)
         vram_mem[i] = ((i & 11'h3FF) >= 11'h3C0) ? attr : 8'h01;
      for (int i = 0; i < 8192; i++) chr_mem[i] = 8'h00;
      for (int y = 0; y < 8; y++) begin
         chr_mem[16'h0010 + y] = lo;
         chr_mem[16'h0018 + y] = hi;
         chr_mem[16'h1010 + y] = lo;
         chr_mem[16'h1018 + y] = hi;
      end
   endtask

   // One dot: push the expected pixel (if any), pulse clk_en, check silence otherwise.
   task automatic tick(input int r, input int c);
      exp_t e;
      logic expect_v;
      row = 9'(r);
      col = 9'(c);
      expect_v = (r < 240) && (c >= 1) && (c <= 256) && tb_primed;
      if (expect_v) begin
         e.r = r;
         e.c = c;
         if (!bg_enable || ((c <= 8) && !show_left8)) e.pix = 4'h0;
         else e.pix = exp_tile[(c - 1) % 8];
         exp_q.push_back(e);
      end
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      if (!expect_v) check($sformatf("valid_low r%0d c%0d", r, c), 32'(bg_valid), 32'h0);
      if ((c == 337) && ((r < 240) || (r == 261))) tb_primed = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic run_span(input int r, input int c0, input int c1);
      for (int c = c0; c <= c1; c++) tick(r, c);
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      clk_en    = 1'b0;
      tb_primed = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic cfg(input logic [7:0] sx, input logic [7:0] sy, input logic [1:0] nt,
                      input logic pt, input logic left);
      scroll_x   = sx;
      scroll_y   = sy;
      name_tbl   = nt;
      patt_tbl   = pt;
      show_left8 = left;
      bg_enable  = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clk_en = 1'b0; row = 9'd0; col = 9'd0; tb_primed = 1'b0;
      cfg(8'd0, 8'd0, 2'd0, 1'b0, 1'b1);
      @(negedge clk);

      // Plain tile, no scroll: pixel at first dot of each tile.
      load_mem(8'h80, 8'h00, 8'h00);
      set_first(4'h1);
      apply_reset();
      check("reset bg_valid", 32'(bg_valid), 32'h0);
      check("reset bg_pix", 32'(bg_pix), 32'h0);
      check("reset vram_addr", 32'(vram_addr), 32'h0);
      check("reset chr_addr", 32'(chr_addr), 32'h0);
      run_span(261, 318, 340);
      check("hold vram_addr outside window", 32'(vram_addr), 32'h3C0);
      run_span(0, 0, 16);
      check("queue drained s1", 32'(exp_q.size()), 32'h0);

      // Fine scroll 3 with bit 4 set: pixel still lands on dot 1 of each tile.
      load_mem(8'h10, 8'h00, 8'h00);
      set_first(4'h1);
      cfg(8'd3, 8'd0, 2'd0, 1'b0, 1'b1);
      apply_reset();
      run_span(261, 318, 340);
      run_span(0, 0, 16);
      check("queue drained s2", 32'(exp_q.size()), 32'h0);

      // Coarse wrap into the right nametable; mid-row register changes ignored.
      load_mem(8'h80, 8'h00, 8'h00);
      cfg(8'hF8, 8'd0, 2'd0, 1'b1, 1'b1);
      apply_reset();
      run_span(261, 318, 320);
      scroll_x = 8'h00;
      patt_tbl = 1'b0;
      tick(261, 321);
      check("wrap tile0 nt addr vert", 32'(vram_addr), 32'h01F);
      check("wrap tile0 nt addr horz", 32'(vram_addr_h), 32'h01F);
      run_span(261, 322, 325);
      check("chr lo addr patt 1", 32'(chr_addr), 32'h1010);
      run_span(261, 326, 327);
      check("chr hi addr patt 1", 32'(chr_addr), 32'h1018);
      run_span(261, 328, 329);
      check("wrap tile1 nt addr vert", 32'(vram_addr), 32'h400);
      check("wrap tile1 nt addr horz", 32'(vram_addr_h), 32'h000);

      // Vertical wrap: scroll_y 232 targeting row 8 gives py 0 and toggles nt[1].
      cfg(8'd0, 8'd232, 2'd0, 1'b0, 1'b1);
      apply_reset();
      run_span(7, 318, 321);
      check("ywrap nt addr vert", 32'(vram_addr), 32'h000);
      check("ywrap nt addr horz", 32'(vram_addr_h), 32'h400);
      run_span(7, 322, 323);
      check("ywrap at addr vert", 32'(vram_addr), 32'h3C0);
      check("ywrap at addr horz", 32'(vram_addr_h), 32'h7C0);

      // Attribute 0xE4, bottom-right quadrant: palette 3, colour 3.
      load_mem(8'h80, 8'h80, 8'hE4);
      set_first(4'hF);
      cfg(8'd16, 8'd16, 2'd0, 1'b0, 1'b1);
      apply_reset();
      run_span(261, 318, 340);
      run_span(0, 0, 16);
      check("queue drained br", 32'(exp_q.size()), 32'h0);

      // Same attribute, top-left quadrant: palette 0.
      set_first(4'h3);
      cfg(8'd0, 8'd0, 2'd0, 1'b0, 1'b1);
      apply_reset();
      run_span(261, 318, 340);
      run_span(0, 0, 16);
      check("queue drained tl", 32'(exp_q.size()), 32'h0);

      // Left-column mask, then reset in mid-row and recovery after the next prefetch.
      load_mem(8'h80, 8'h00, 8'h00);
      set_first(4'h1);
      cfg(8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
      apply_reset();
      run_span(261, 318, 340);
      run_span(0, 0, 100);
      rst_n = 1'b0;
      #1;
      check("midrow reset bg_valid", 32'(bg_valid), 32'h0);
      check("midrow reset bg_pix", 32'(bg_pix), 32'h0);
      check("midrow reset vram_addr", 32'(vram_addr), 32'h0);
      check("midrow reset chr_addr", 32'(chr_addr), 32'h0);
      @(negedge clk);
      rst_n      = 1'b1;
      tb_primed  = 1'b0;
      show_left8 = 1'b1;
      run_span(0, 101, 110);
      run_span(0, 318, 340);
      run_span(1, 0, 16);
      bg_enable = 1'b0;
      run_span(1, 17, 20);
      bg_enable = 1'b1;
      run_span(240, 1, 3);
      check("queue drained final", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bg_fetch_pipe.md
Name: bg_fetch_pipe

Overview:
- Successor to the combinational background pixel lookup. Fetches background tiles through a sequential 8-dot pipeline using nametable, attribute, pattern-lo and pattern-hi reads.
- Buffers the fetched data in 16-bit shift registers.
- Supports fine and coarse X/Y scroll, four logical nametables with parametrised mirroring, and left-column masking.
- Sits between the PPU timing counters and the pixel compositor. Emits a 4-bit background palette index per visible dot.

Parameters:
- MIRROR_MODE, 1, nametable mirroring: 0 = horizontal (phys A10 = logical nt[1]); 1 = vertical (phys A10 = logical nt[0]).
- VIS_ROWS, 240, number of visible rows; pre-render row = 261.
- PREFETCH_START, 321, first dot of next-row prefetch; prefetch covers 16 dots.

Ports:
- clk  in  1  master clock
- clk_en  in  1  dot enable (master/4); all state advances only when high
- rst_n  in  1  asynchronous reset, active low
- row  in  9  current scanline, 0..261
- col  in  9  current dot, 0..340
- bg_enable  in  1  rendering enable for background
- show_left8  in  1  1 = draw background in dots 1..8
- name_tbl  in  2  base logical nametable (0 TL, 1 TR, 2 BL, 3 BR)
- patt_tbl  in  1  0 = pattern base 0x0000, 1 = 0x1000
- scroll_x  in  8  horizontal scroll, bits[2:0] fine, [7:3] coarse
- scroll_y  in  8  vertical scroll, 0..239
- vram_addr  out  11  nametable/attribute read address
- vram_data  in  8  sync read data, valid on the clk_en tick after the address
- chr_addr  out  13  pattern read address
- chr_data  in  8  sync read data, same latency as vram
- bg_pix  out  4  {attr_pal[1:0], color[1:0]}; 0 when transparent
- bg_valid  out  1  bg_pix corresponds to visible dot col-1

Behaviour:
- Reset values:
  - All registers 0, including the shifters, latches and sampled scroll.
  - vram_addr = 0, chr_addr = 0, bg_pix = 0, bg_valid = 0.
- Scroll sampling:
  - scroll_x/y, name_tbl and patt_tbl are sampled into shadow registers on the clk_en tick with col == 320.
  - The shadow values apply to the prefetch and the entire following row.
  - Changes mid-row have no effect.
- Fetch windows:
  - Fetches run at dots 1..256 and 321..336 on rows 0..VIS_ROWS-1 and row 261, and only when bg_enable = 1.
  - Outside the windows, addresses hold their last value.
- Fetch cycle, with phase = (col-1)[2:0]:
  - phase 0: drive NT address.
  - phase 1: latch nt byte.
  - phase 2: drive AT address.
  - phase 3: latch attr byte and select its 2-bit quadrant.
  - phase 4: drive chr lo address = base + {nt, 0, fy}.
  - phase 5: latch lo.
  - phase 6: drive chr hi address = lo address + 8.
  - phase 7: latch hi.
- Tile coordinates:
  - Fetch tile n: n = ((col-1)>>3)+2 in the visible window, 0/1 in the prefetch.
  - px = coarse_x*8 + n*8, taken mod 512; bit 8 toggles logical nt[0].
  - py = scroll_y + target row, where target row = row+1 in prefetch (0 when row = 261).
  - When py ≥ 240: subtract 240 and toggle logical nt[1].
  - fy = py[2:0].
  - NT address = {phys_A10, py[7:3], px[7:3]}.
  - AT address = {phys_A10, 4'hF, py[7:5], px[7:5]}.
  - Quadrant select: shift = {py[4], px[4], 0}.
- Shift reload:
  - On dots 9, 17, ..., 257, 329 and 337, the latched lo/hi/attr-bit pairs load into the low 8 bits of the pattern and attribute shifters.
  - The attribute shifters are replicated 8×.
- Shifting: shifters shift left by one on dots 2..257 and 322..337.
- Pixel output:
  - On visible rows at dots 1..256, select bit (15 - fine_x) from each shifter.
  - bg_pix is registered and appears the same clk_en tick, with bg_valid = 1.
  - If color == 0, bg_pix = 0 (universal backdrop).
  - If bg_enable = 0, or if col ≤ 8 with show_left8 = 0, bg_pix = 0 but bg_valid = 1.
  - Outside visible dots or rows, bg_valid = 0 and bg_pix = 0.
- Reset assertion: clears state immediately regardless of clk_en. After release, output is garbage-free: 0 until the next prefetch completes.

Test Plan:
- No scroll, MIRROR_MODE = 1, NT[0] = 0x01 at every tile, pattern tile 1 row 0 lo = 0x80 hi = 0x00, attr = 0x00 -> row 0 dot 1 bg_pix = 0x1, dots 2..8 bg_pix = 0.
- scroll_x = 3, same data, lo = 0x10 -> pixel appears at dot 1 (bit 4 → fine offset 3), dot 2 = 0.
- Coarse wrap: scroll_x = 0xF8, name_tbl = 0 -> second fetched tile reads vram_addr with A10 = 1 (vertical); with MIRROR_MODE = 0, A10 stays 0.
- scroll_y = 232, row 8 -> py = 240 wraps to 0, nt[1] toggles: vertical mirroring keeps A10 = 0, AT address = 0x3C0.
- attr = 0xE4, tiles at quadrant BR -> bg_pix[3:2] = 3; TL -> 0; colour 0 -> bg_pix = 0 regardless of attr.
- show_left8 = 0 -> dots 1..8 bg_pix = 0, dot 9 normal. Assert rst_n low at col 100 -> all outputs 0 next edge, bg_valid = 0 until col 1 of next visible row after prefetch.
